// File: rtl/lif_spike_arbiter.sv
// lif_spike_arbiter: latches per-timestep spikes from N LIF neurons and
// serialises them as AER addresses on one valid/ready channel, choosing the
// next neuron round-robin. Re-fires of a neuron whose event is still queued
// are counted as drops in a saturating counter.
//
// Handshake: an event moves when ev_valid && ev_ready at a rising edge. Once
// ev_valid is high, ev_addr is held stable and ev_valid stays high until that
// transfer happens; only rst_n can withdraw an offered event.
module lif_spike_arbiter #(
    parameter int N  = 8,
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [N-1:0]  spike_in,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [AW-1:0] ev_addr,
    output logic [N-1:0]  pending,
    output logic          busy,
    output logic [DW-1:0] drop_cnt,
    input  logic          drop_clr,
    output logic          dbg_state,
    output logic [AW-1:0] dbg_rr_ptr
);

    localparam int CW = $clog2(N + 1);
    localparam int SW = ((DW > CW) ? DW : CW) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   rr_ptr;
    logic            valid_d;
    logic [AW-1:0]   addr_d;
    logic [N-1:0]    load;
    logic [N-1:0]    pending_d;
    logic [N-1:0]    dropped;
    logic [N-1:0]    search_vec;
    logic [AW-1:0]   search_ptr;
    logic [AW-1:0]   ptr_inc;
    logic [AW:0]     pick;
    logic            xfer;
    logic [SW-1:0]   drop_sum;
    logic [DW-1:0]   drop_d;

    // First set bit of vec at or above ptr, wrapping N-1 -> 0.
    // Result is {found, index}; scanning from the far end lets the nearest hit win.
    function automatic logic [AW:0] rr_pick(input logic [N-1:0] vec, input logic [AW-1:0] ptr);
        logic [AW:0] r;
        int          idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (vec[idx]) r = {1'b1, AW'(idx)};
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    assign xfer       = ev_valid && ev_ready;
    assign ptr_inc    = (ev_addr == AW'(N - 1)) ? '0 : ev_addr + AW'(1);
    assign busy       = ev_valid || (pending != '0);
    assign dbg_state  = (state == SEND);
    assign dbg_rr_ptr = rr_ptr;

    // Arbitration input: in SEND the next pick is made as if the current
    // transfer had already completed (its bit excluded, pointer advanced).
    always_comb begin
        search_vec = pending;
        search_ptr = rr_ptr;
        if (state == SEND) begin
            search_ptr = ptr_inc;
            for (int i = 0; i < N; i++) begin
                if (AW'(i) == ev_addr) search_vec[i] = 1'b0;
            end
        end
    end

    assign pick = rr_pick(search_vec, search_ptr);

    // FSM next state, output-register load and per-bit load strobe.
    always_comb begin
        state_d = state;
        valid_d = ev_valid;
        addr_d  = ev_addr;
        load    = '0;
        case (state)
            IDLE: begin
                valid_d = 1'b0;
                if (pick[AW]) begin
                    addr_d           = pick[AW-1:0];
                    load[pick[AW-1:0]] = 1'b1;
                    valid_d          = 1'b1;
                    state_d          = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (pick[AW]) begin
                        addr_d           = pick[AW-1:0];
                        load[pick[AW-1:0]] = 1'b1;
                        valid_d          = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Pending latch and drop detection; a fresh spike on the bit being loaded re-queues it.
    always_comb begin
        pending_d = (pending & ~load) | ({N{ena}} & spike_in);
        dropped   = {N{ena}} & spike_in & pending & ~load;
        drop_sum  = (drop_clr ? SW'(0) : SW'(drop_cnt)) + SW'(popcount(dropped));
        drop_d    = (drop_sum > SW'({DW{1'b1}})) ? {DW{1'b1}} : drop_sum[DW-1:0];
    end

    // State, output channel, pending vector and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_addr  <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_d;
            ev_valid <= valid_d;
            ev_addr  <= addr_d;
            pending  <= pending_d;
            if (xfer) rr_ptr <= ptr_inc;
        end
    end

    // Saturating drop counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_d;
    end

endmodule

// File: tb/tb_lif_spike_arbiter.sv
// Directed bench for lif_spike_arbiter (N=8, AW=3, DW=8). Inputs change 1ns
// after each rising edge; outputs are checked at that same point, before the
// inputs move, so every check sees the state left by the previous edge.
module tb_lif_spike_arbiter;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [N-1:0]  spike_in;
    logic          ev_valid;
    logic          ev_ready;
    logic [AW-1:0] ev_addr;
    logic [N-1:0]  pending;
    logic          busy;
    logic [DW-1:0] drop_cnt;
    logic          drop_clr;
    logic          dbg_state;
    logic [AW-1:0] dbg_rr_ptr;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;

    lif_spike_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .pending    (pending),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .drop_clr   (drop_clr),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        spike_in = '0;
        ev_ready = 1'b1;
        drop_clr = 1'b0;
        tick();
        tick();
        check("rst_valid",   64'(ev_valid),   0);
        check("rst_addr",    64'(ev_addr),    0);
        check("rst_pending", 64'(pending),    0);
        check("rst_busy",    64'(busy),       0);
        check("rst_drop",    64'(drop_cnt),   0);
        check("rst_rr",      64'(dbg_rr_ptr), 0);
        check("rst_state",   64'(dbg_state),  0);
        rst_n = 1'b1;
        tick();

        // Burst: all eight neurons fire, drained 0..7 at one per cycle.
        spike_in = 8'hFF;
        tick();
        spike_in = '0;
        check("burst_pend", 64'(pending), 64'hFF);
        tick();
        for (int i = 0; i < N; i++) exp_q.push_back(AW'(i));
        while (exp_q.size() > 0) begin
            exp_addr = exp_q.pop_front();
            check("burst_valid", 64'(ev_valid), 1);
            check("burst_addr",  64'(ev_addr),  64'(exp_addr));
            tick();
        end
        check("burst_end_valid", 64'(ev_valid),   0);
        check("burst_end_rr",    64'(dbg_rr_ptr), 0);
        check("burst_end_busy",  64'(busy),       0);

        // Single spike on neuron 4: valid two edges after the spike, for one cycle.
        spike_in = 8'h10;
        tick();
        spike_in = '0;
        check("single_pend",   64'(pending),  64'h10);
        check("single_early",  64'(ev_valid), 0);
        tick();
        check("single_valid",  64'(ev_valid), 1);
        check("single_addr",   64'(ev_addr),  4);
        tick();
        check("single_done",   64'(ev_valid),   0);
        check("single_busy",   64'(busy),       0);
        check("single_drop",   64'(drop_cnt),   0);
        check("single_rr",     64'(dbg_rr_ptr), 5);

        // Round-robin: after addr 5 moves, bits 0 and 5 are served 0 first.
        spike_in = 8'h20;
        tick();
        spike_in = '0;
        tick();
        check("rr_a5", 64'(ev_addr), 5);
        tick();
        check("rr_ptr6", 64'(dbg_rr_ptr), 6);
        spike_in = 8'h21;
        tick();
        spike_in = '0;
        tick();
        check("rr_first_valid", 64'(ev_valid), 1);
        check("rr_first",       64'(ev_addr),  0);
        tick();
        check("rr_second_valid", 64'(ev_valid), 1);
        check("rr_second",       64'(ev_addr),  5);
        tick();
        check("rr_done", 64'(ev_valid), 0);

        // Backpressure: addr 0 held through a 5-cycle stall, then 0 and 2 back to back.
        ev_ready = 1'b0;
        spike_in = 8'h05;
        tick();
        spike_in = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(ev_valid), 1);
            check("bp_addr",  64'(ev_addr),  0);
            check("bp_pend",  64'(pending),  64'h04);
            tick();
        end
        ev_ready = 1'b1;
        check("bp_rel_addr", 64'(ev_addr), 0);
        tick();
        check("bp_next_valid", 64'(ev_valid), 1);
        check("bp_next_addr",  64'(ev_addr),  2);
        tick();
        check("bp_done",   64'(ev_valid),   0);
        check("bp_rr",     64'(dbg_rr_ptr), 3);

        // Drops: neuron 0 stuck in the output register, neuron 3 pulses 300 times.
        ev_ready = 1'b0;
        spike_in = 8'h01;
        tick();
        spike_in = '0;
        tick();
        check("drop_hold_addr", 64'(ev_addr), 0);
        for (int p = 1; p <= 300; p++) begin
            spike_in = 8'h08;
            tick();
            if (p == 1) begin
                check("drop_first_queued", 64'(pending),  64'h08);
                check("drop_first_cnt",    64'(drop_cnt), 0);
            end
            if (p == 2)   check("drop_second", 64'(drop_cnt), 1);
            if (p == 100) check("drop_p100",   64'(drop_cnt), 99);
            if (p == 256) check("drop_sat",    64'(drop_cnt), 255);
            if (p == 300) check("drop_sat_end", 64'(drop_cnt), 255);
        end
        drop_clr = 1'b1;
        tick();
        check("drop_clr_fire", 64'(drop_cnt), 1);
        spike_in = '0;
        drop_clr = 1'b0;
        tick();
        check("drop_hold", 64'(drop_cnt), 1);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("drop_clr_idle", 64'(drop_cnt), 0);
        check("drop_valid_held", 64'(ev_valid), 1);

        // Reset mid-operation with an event offered and pending=0C.
        spike_in = 8'h04;
        tick();
        spike_in = '0;
        check("mid_pend",  64'(pending),  64'h0C);
        check("mid_valid", 64'(ev_valid), 1);
        rst_n    = 1'b0;
        ev_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", 64'(ev_valid),   0);
        check("mrst_pend",  64'(pending),    0);
        check("mrst_drop",  64'(drop_cnt),   0);
        check("mrst_rr",    64'(dbg_rr_ptr), 0);
        tick();
        check("mrst_after_valid", 64'(ev_valid), 0);
        check("mrst_after_busy",  64'(busy),     0);

        // Gating: spikes ignored while ena is low.
        ena      = 1'b0;
        spike_in = 8'hFF;
        tick();
        check("gate_pend", 64'(pending), 0);
        check("gate_busy", 64'(busy),    0);
        tick();
        spike_in = '0;
        check("gate_busy2", 64'(busy),     0);
        check("gate_drop",  64'(drop_cnt), 0);
        ena = 1'b1;
        tick();

        // Re-spike on the bit being loaded is queued again, not dropped.
        spike_in = 8'h02;
        tick();
        tick();
        spike_in = '0;
        check("respike_addr", 64'(ev_addr),  1);
        check("respike_pend", 64'(pending),  64'h02);
        check("respike_drop", 64'(drop_cnt), 0);
        tick();
        check("respike_gap",  64'(ev_valid), 0);
        tick();
        check("respike_again_valid", 64'(ev_valid), 1);
        check("respike_again_addr",  64'(ev_addr),  1);
        tick();
        check("respike_done", 64'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
